// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 scan-code prefix decoder feeding a fall-through event FIFO, with error recovery
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   rxData/rxReady/rxError byte, data-ready level and error level from the PS/2 receiver
//   rxReset               reset pulse back to the receiver (also high while reset=1)
//   evCode/evBreak/evExt  head event of the FIFO, evValid when non-empty, evTake pops
//   overflow/ovfClear     sticky drop flag and its clear
//   errCount              saturating count of receiver errors
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxData,
    input  logic       rxReady,
    input  logic       rxError,
    output logic       rxReset,
    output logic [7:0] evCode,
    output logic       evBreak,
    output logic       evExt,
    output logic       evValid,
    input  logic       evTake,
    output logic       overflow,
    input  logic       ovfClear,
    output logic [7:0] errCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [RW-1:0] RC_TOP = RW'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic          rdy_q, err_q;
    logic          rec_q, rec_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    ecnt_q, ecnt_d;
    logic          err_rise, byte_ok, is_e0, is_f0, push, pop, full, wr;

    // An error edge wins over a simultaneous byte edge; both are ignored while recovering.
    assign err_rise = rxError && !err_q && !rec_q;
    assign byte_ok  = rxReady && !rdy_q && !rec_q && !err_rise;
    assign is_e0    = rxData == 8'hE0;
    assign is_f0    = rxData == 8'hF0;
    assign push     = byte_ok && !is_e0 && !is_f0;
    assign pop      = evTake && evValid;
    assign full     = cnt_q == FULL;
    assign wr       = push && (!full || pop);

    always_comb begin
        state_d = state_q;
        if (err_rise)
            state_d = IDLE;
        else if (byte_ok)
            state_d = is_e0 ? EXT :
                      is_f0 ? ((state_q == IDLE) ? BRK : (state_q == EXT) ? EXT_BRK : state_q) :
                      IDLE;
    end

    always_comb begin
        rec_d  = rec_q;
        rcnt_d = rcnt_q;
        if (rec_q) begin
            rec_d  = rcnt_q != '0;
            rcnt_d = (rcnt_q != '0) ? rcnt_q - 1'b1 : '0;
        end else if (err_rise) begin
            rec_d  = 1'b1;
            rcnt_d = RC_TOP;
        end
    end

    assign cnt_d  = cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
    // A drop takes priority over a coincident clear.
    assign ovf_d  = (push && full && !pop) ? 1'b1 : ovfClear ? 1'b0 : ovf_q;
    assign ecnt_d = (err_rise && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rec_q   <= 1'b1;
            rcnt_q  <= RC_TOP;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            // Edge copies are held at 0 while recovering so a level still high afterwards counts as a new edge.
            rdy_q   <= rec_q ? 1'b0 : rxReady;
            err_q   <= rec_q ? 1'b0 : rxError;
            rec_q   <= rec_d;
            rcnt_q  <= rcnt_d;
            wp_q    <= wp_q + AW'(wr);
            rp_q    <= rp_q + AW'(pop);
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp_q] <= {state_q == BRK || state_q == EXT_BRK, state_q == EXT || state_q == EXT_BRK, rxData};
    end

    assign rxReset                   = rec_q;
    assign evValid                   = cnt_q != '0;
    assign {evBreak, evExt, evCode}  = evValid ? mem[rp_q] : 10'd0;
    assign overflow                  = ovf_q;
    assign errCount                  = ecnt_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: self-checking bench for ps2_kbd_ctrl using a queue-based reference model
module tb_ps2_kbd_ctrl;
    localparam int D  = 4;
    localparam int RC = 2;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxReady = 1'b0, rxError = 1'b0, evTake = 1'b0, ovfClear = 1'b0;
    logic       rxReset, evBreak, evExt, evValid, overflow;
    logic [7:0] evCode, errCount;
    int         tests = 0, fails = 0;

    ps2_kbd_ctrl #(.FIFO_DEPTH(D), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .rxData(rxData), .rxReady(rxReady), .rxError(rxError),
        .rxReset(rxReset), .evCode(evCode), .evBreak(evBreak), .evExt(evExt), .evValid(evValid),
        .evTake(evTake), .overflow(overflow), .ovfClear(ovfClear), .errCount(errCount)
    );

    always #5 clk = ~clk;

    // Reference model: events as {break, ext, code}, prefix kept as two flags.
    logic [9:0] mq[$];
    bit         m_brk, m_ext, m_ovf, m_prdy, m_perr;
    int         m_err, m_rec;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic model_step();
        bit         pop, drop, pushing;
        logic [9:0] ev;
        ev = '0;
        pushing = 0;
        if (reset) begin
            mq.delete();
            m_brk = 0; m_ext = 0; m_ovf = 0; m_prdy = 0; m_perr = 0; m_err = 0; m_rec = RC;
            return;
        end
        pop = evTake && mq.size() > 0;
        if (m_rec > 0) begin
            m_rec--;
            m_prdy = 0;
            m_perr = 0;
        end else begin
            if (rxError && !m_perr) begin
                m_rec = RC; m_brk = 0; m_ext = 0;
                if (m_err < 255) m_err++;
            end else if (rxReady && !m_prdy) begin
                if (rxData == 8'hE0) begin m_ext = 1; m_brk = 0; end
                else if (rxData == 8'hF0) m_brk = 1;
                else begin
                    pushing = 1;
                    ev = {m_brk, m_ext, rxData};
                    m_brk = 0; m_ext = 0;
                end
            end
            m_prdy = rxReady;
            m_perr = rxError;
        end
        if (pop) void'(mq.pop_front());
        drop = pushing && mq.size() >= D;
        if (pushing && !drop) mq.push_back(ev);
        m_ovf = drop ? 1'b1 : ovfClear ? 1'b0 : m_ovf;
    endtask

    task automatic cmp_model();
        logic [9:0] head;
        head = '0;
        if (mq.size() > 0) head = mq[0];
        chk("model.valid", 32'(evValid), 32'(mq.size() > 0));
        chk("model.head", 32'({evBreak, evExt, evCode}), 32'(head));
        chk("model.ovf", 32'(overflow), 32'(m_ovf));
        chk("model.errcnt", 32'(errCount), 32'(m_err));
        chk("model.rxreset", 32'(rxReset), 32'(reset || m_rec > 0));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxData = b;
        rxReady = 1'b1;
        tick();
        rxReady = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string n, input logic [9:0] exp);
        chk({n, ".valid"}, 32'(evValid), 32'(1));
        chk({n, ".head"}, 32'({evBreak, evExt, evCode}), 32'(exp));
        evTake = 1'b1;
        tick();
        evTake = 1'b0;
    endtask

    task automatic wait_rec(output int n);
        n = 0;
        while (rxReset && n < 20) begin
            n++;
            tick();
        end
    endtask

    typedef struct packed {
        logic [7:0] b0, b1, b2;
        logic [1:0] n;
        logic       brk, ext;
        logic [7:0] code;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        tbl[0]  = '{8'h1C, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'h1C};
        tbl[1]  = '{8'hF0, 8'h1C, 8'h00, 2'd2, 1'b1, 1'b0, 8'h1C};
        tbl[2]  = '{8'hE0, 8'hF0, 8'h75, 2'd3, 1'b1, 1'b1, 8'h75};
        tbl[3]  = '{8'hE0, 8'h75, 8'h00, 2'd2, 1'b0, 1'b1, 8'h75};
        tbl[4]  = '{8'hF0, 8'hF0, 8'h1C, 2'd3, 1'b1, 1'b0, 8'h1C};
        tbl[5]  = '{8'hE0, 8'hE0, 8'h6B, 2'd3, 1'b0, 1'b1, 8'h6B};
        tbl[6]  = '{8'hF0, 8'hE0, 8'h11, 2'd3, 1'b0, 1'b1, 8'h11};
        tbl[7]  = '{8'hAA, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'hAA};
        tbl[8]  = '{8'hE0, 8'hFA, 8'h00, 2'd2, 1'b0, 1'b1, 8'hFA};
        tbl[9]  = '{8'hF0, 8'hE1, 8'h00, 2'd2, 1'b1, 1'b0, 8'hE1};
        tbl[10] = '{8'hFE, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'hFE};

        reset = 1'b1;
        tick();
        tick();
        chk("rst.valid", 32'(evValid), 0);
        chk("rst.code", 32'({evBreak, evExt, evCode}), 0);
        chk("rst.rxreset", 32'(rxReset), 1);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.errcnt", 32'(errCount), 0);
        reset = 1'b0;
        wait_rec(n);
        chk("rst.pulse_len", n, RC);
        chk("rst.pulse_errcnt", 32'(errCount), 0);

        // Latency: event appears right after the edge that samples the rxReady rise.
        rxData = 8'h1C;
        rxReady = 1'b1;
        chk("lat.before", 32'(evValid), 0);
        tick();
        chk("lat.after", 32'(evValid), 1);
        rxReady = 1'b0;
        tick();
        pop_chk("lat.pop", 10'h01C);
        chk("lat.empty", 32'(evValid), 0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].n >= 1) send_byte(tbl[i].b0);
            if (tbl[i].n >= 2) send_byte(tbl[i].b1);
            if (tbl[i].n >= 3) send_byte(tbl[i].b2);
            pop_chk($sformatf("tbl%0d", i), {tbl[i].brk, tbl[i].ext, tbl[i].code});
            chk($sformatf("tbl%0d.empty", i), 32'(evValid), 0);
        end

        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("ovf.set", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf.pop%0d", i), 10'(i));
        chk("ovf.empty", 32'(evValid), 0);
        chk("ovf.sticky", 32'(overflow), 1);
        ovfClear = 1'b1;
        tick();
        ovfClear = 1'b0;
        chk("ovf.clear", 32'(overflow), 0);

        // Drop and clear in the same cycle leave the flag set.
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        rxData = 8'h34;
        rxReady = 1'b1;
        ovfClear = 1'b1;
        tick();
        rxReady = 1'b0;
        ovfClear = 1'b0;
        tick();
        chk("ovfclr.coincide", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("ovfclr.pop%0d", i), 10'h30 + 10'(i));
        ovfClear = 1'b1;
        tick();
        ovfClear = 1'b0;

        send_byte(8'hE0);
        rxError = 1'b1;
        tick();
        rxError = 1'b0;
        wait_rec(n);
        chk("err.pulse_len", n, RC);
        chk("err.errcnt", 32'(errCount), 1);
        send_byte(8'h75);
        pop_chk("err.after", 10'h075);
        chk("err.empty", 32'(evValid), 0);

        rxData = 8'h33;
        rxReady = 1'b1;
        rxError = 1'b1;
        tick();
        rxReady = 1'b0;
        rxError = 1'b0;
        wait_rec(n);
        tick();
        chk("both.no_event", 32'(evValid), 0);
        chk("both.errcnt", 32'(errCount), 2);

        rxData = 8'h2A;
        rxReady = 1'b1;
        repeat (10) tick();
        rxReady = 1'b0;
        tick();
        pop_chk("held.one", 10'h02A);
        chk("held.empty", 32'(evValid), 0);

        for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
        rxData = 8'h45;
        rxReady = 1'b1;
        evTake = 1'b1;
        tick();
        rxReady = 1'b0;
        evTake = 1'b0;
        tick();
        chk("fullpp.ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("fullpp.pop%0d", i), 10'h42 + 10'(i));
        chk("fullpp.empty", 32'(evValid), 0);

        send_byte(8'h51);
        send_byte(8'h52);
        rxError = 1'b1;
        tick();
        rxError = 1'b0;
        chk("recpop.rxreset", 32'(rxReset), 1);
        evTake = 1'b1;
        tick();
        evTake = 1'b0;
        wait_rec(n);
        pop_chk("recpop.kept", 10'h052);
        chk("recpop.empty", 32'(evValid), 0);

        send_byte(8'h61);
        send_byte(8'hF0);
        #2 reset = 1'b1;
        #1;
        chk("midrst.valid", 32'(evValid), 0);
        chk("midrst.errcnt", 32'(errCount), 0);
        chk("midrst.rxreset", 32'(rxReset), 1);
        tick();
        reset = 1'b0;
        wait_rec(n);
        send_byte(8'h62);
        pop_chk("midrst.noprefix", 10'h062);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                if (!rxReady) begin
                    case ($urandom_range(0, 7))
                        0: rxData = 8'hE0;
                        1: rxData = 8'hF0;
                        default: rxData = 8'($urandom);
                    endcase
                end
                rxReady = ~rxReady;
            end
            rxError  = $urandom_range(0, 40) == 0;
            evTake   = $urandom_range(0, 2) == 0;
            ovfClear = $urandom_range(0, 15) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
